// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared types and constants for the PC redirect controller
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        WAIT   = 2'd2,
        SQUASH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_HOLD   = 2'd3
    } pc_sel_t;

    localparam logic [31:0] PC_INCR              = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_ctrl_next_pc_sel.sv
// rtl/pc_redirect_ctrl_next_pc_sel.sv - next-PC source priority and pipeline strobes for RUN/WAIT
module next_pc_sel
    import pc_redirect_ctrl_pkg::*;
(
    input  logic    taken,
    input  logic    id_jump,
    input  logic    stall,
    input  logic    ready,
    output pc_sel_t sel,
    output logic    if_id_write,
    output logic    if_id_flush,
    output logic    id_ex_flush,
    output logic    redirect
);

    // Branch beats jump (jump is on the wrong path), and branch beats stall
    // (the stalled instruction gets flushed anyway).
    always_comb begin
        sel         = SEL_SEQ;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = 1'b0;
        if (taken) begin
            sel         = SEL_BRANCH;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
        end else if (id_jump) begin
            sel         = SEL_JUMP;
            if_id_flush = 1'b1;
            redirect    = 1'b1;
        end else if (stall) begin
            sel         = SEL_HOLD;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!ready) begin
            sel         = SEL_HOLD;
            if_id_write = 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC register owner and redirect sequencer for the 5-stage pipeline
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR     = RESET_VECTOR_DEFAULT,
    parameter int          REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_branch,
    input  logic        ex_branch_ne,
    input  logic        ex_zero,
    input  logic [31:0] ex_target,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        redirect
);

    localparam logic        HAS_SQUASH  = (REDIRECT_BUBBLES > 0);
    // Counter is loaded with bubbles-1 so SQUASH lasts exactly REDIRECT_BUBBLES cycles.
    localparam logic [1:0]  SQUASH_INIT = HAS_SQUASH ? 2'(REDIRECT_BUBBLES - 1) : 2'd0;
    localparam logic [31:0] RESET_PC    = {RESET_VECTOR[31:2], 2'b00};

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;
    logic [31:0] pc_mux;
    logic        taken;

    pc_sel_t     sel;
    logic        sel_if_id_write;
    logic        sel_if_id_flush;
    logic        sel_id_ex_flush;
    logic        sel_redirect;

    assign taken = ex_branch & (ex_branch_ne ? ~ex_zero : ex_zero);

    next_pc_sel u_next_pc_sel (
        .taken       (taken),
        .id_jump     (id_jump),
        .stall       (hazard_stall),
        .ready       (imem_ready),
        .sel         (sel),
        .if_id_write (sel_if_id_write),
        .if_id_flush (sel_if_id_flush),
        .id_ex_flush (sel_id_ex_flush),
        .redirect    (sel_redirect)
    );

    // Next state, next PC and strobes; BOOT/SQUASH defaults keep both pipeline registers flushed.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_mux      = pc;
        fetch_valid = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        redirect    = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN, WAIT: begin
                fetch_valid = 1'b1;
                if_id_write = sel_if_id_write;
                if_id_flush = sel_if_id_flush;
                id_ex_flush = sel_id_ex_flush;
                redirect    = sel_redirect;
                case (sel)
                    SEL_BRANCH: pc_mux = ex_target;
                    SEL_JUMP:   pc_mux = id_jump_target;
                    SEL_SEQ:    pc_mux = pc + PC_INCR;
                    default:    pc_mux = pc;
                endcase
                if (taken) begin
                    if (HAS_SQUASH) begin
                        state_next = SQUASH;
                        cnt_next   = SQUASH_INIT;
                    end else begin
                        state_next = RUN;
                    end
                end else if (id_jump) begin
                    state_next = RUN;
                end else begin
                    state_next = imem_ready ? RUN : WAIT;
                end
            end
            SQUASH: begin
                if (cnt == 2'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // PC register; fetch addresses are always word aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= {pc_mux[31:2], 2'b00};
        end
    end

    // Squash bubble counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule
